// File: rtl/zigzag_pingpong_buffer.sv
// Two-bank 8x8 coefficient store: rows are written raster-order into one bank while the
// other bank drains one coefficient per beat in JPEG zigzag order through a 1-entry output register.
module zigzag_pingpong_buffer #(
    parameter int DATA_WIDTH = 10,
    parameter int BLOCK_DIM  = 8,
    parameter int IDX_WIDTH  = 6
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BLOCK_DIM*DATA_WIDTH-1:0] in_row_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [IDX_WIDTH-1:0]            out_index,
    output logic                            out_last,
    output logic [1:0]                      bank_full
);

    // Handshakes: a beat transfers on a rising edge where valid && ready; valid never waits on
    // ready, and a presented output beat holds data/index/last stable until it is taken.

    if (BLOCK_DIM != 8 || IDX_WIDTH != 6) begin : g_bad_geometry
        $error("zigzag_pingpong_buffer: BLOCK_DIM must be 8 and IDX_WIDTH must be 6");
    end

    localparam int                   NUM_COEF = BLOCK_DIM * BLOCK_DIM;
    localparam logic [2:0]           LAST_ROW = 3'(BLOCK_DIM - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COEF - 1);

    // Zigzag position k -> raster address row*8+col.
    localparam logic [IDX_WIDTH-1:0] ZZ [NUM_COEF] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [DATA_WIDTH-1:0] mem_q [0:2*NUM_COEF-1];

    logic                  wr_bank_q,   wr_bank_d;
    logic [2:0]            wr_row_q,    wr_row_d;
    logic                  rd_bank_q,   rd_bank_d;
    logic [IDX_WIDTH-1:0]  rd_cnt_q,    rd_cnt_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [IDX_WIDTH-1:0]  out_index_q, out_index_d;
    logic                  out_last_q,  out_last_d;

    logic                  in_fire;
    logic                  rd_load;
    logic [IDX_WIDTH:0]    rd_addr;

    // in_ready depends on state and clear only, never on in_valid.
    assign in_ready = !bank_full_q[wr_bank_q] && !clear;
    assign in_fire  = in_valid && in_ready;
    assign rd_load  = (!out_valid_q || out_ready) && bank_full_q[rd_bank_q] && !clear;
    assign rd_addr  = {rd_bank_q, ZZ[rd_cnt_q]};

    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_row_d    = wr_row_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        bank_full_d = bank_full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;

        if (clear) begin
            wr_bank_d   = 1'b0;
            wr_row_d    = '0;
            rd_bank_d   = 1'b0;
            rd_cnt_d    = '0;
            bank_full_d = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_index_d = '0;
            out_last_d  = 1'b0;
        end else begin
            if (in_fire) begin
                if (wr_row_q == LAST_ROW) begin
                    bank_full_d[wr_bank_q] = 1'b1;
                    wr_bank_d              = !wr_bank_q;
                    wr_row_d               = '0;
                end else begin
                    wr_row_d = wr_row_q + 3'd1;
                end
            end

            // The write and read banks always differ when both act, so both flag updates land.
            if (rd_load) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[rd_addr];
                out_index_d = rd_cnt_q;
                out_last_d  = (rd_cnt_q == LAST_IDX);
                if (rd_cnt_q == LAST_IDX) begin
                    bank_full_d[rd_bank_q] = 1'b0;
                    rd_bank_d              = !rd_bank_q;
                    rd_cnt_d               = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_q   <= 1'b0;
            wr_row_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            bank_full_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_row_q    <= wr_row_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            bank_full_q <= bank_full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    // Storage is wiped by clear as well, so no stale partial block survives an abort.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2*NUM_COEF; i++) mem_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < 2*NUM_COEF; i++) mem_q[i] <= '0;
        end else if (in_fire) begin
            for (int j = 0; j < BLOCK_DIM; j++) begin
                mem_q[{wr_bank_q, wr_row_q, 3'(j)}] <= in_row_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign bank_full = bank_full_q;

endmodule
